port_recv_buffer: RTL and testbench

Receiving end of the router's inter-node link. Accepts one package per cycle from an upstream transmitter, where a package is a 2-bit direction plus payload, and stores it in a small FIFO. It returns a registered per-package `fail` flag one cycle later, which the upstream transport stage uses to clear or retry the rejected direction. The FIFO head is presented show-ahead to the local route/judge stage, which pops it.

---
 rtl/router_pkg.sv | 21 ++
 rtl/port_recv_buffer_if.sv | 25 ++
 rtl/recv_fifo.sv | 64 ++++++
 rtl/port_recv_buffer.sv | 66 ++++++
 tb/tb_port_recv_buffer.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router link types: direction codes and package layout
package router_pkg;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_X     = 2'b01;
    localparam logic [1:0] DIR_Y     = 2'b10;
    localparam logic [1:0] DIR_LOCAL = 2'b11;

    localparam int PKT_DATA_W = 8;

    // Default-width package as carried between transport, receive and judge stages.
    typedef struct packed {
        logic [1:0]            dir;
        logic [PKT_DATA_W-1:0] data;
    } pkt_t;

    function automatic logic dir_valid(input logic [1:0] dir);
        return dir != DIR_NONE;
    endfunction

endpackage

// File: rtl/port_recv_buffer_if.sv
// rtl/port_recv_buffer_if.sv - link-side and judge-side signals of the receive buffer
interface port_recv_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                     enable;
    logic [1:0]               din_dir;
    logic [DATA_W-1:0]        din_data;
    logic                     fail;
    logic [1:0]               dout_dir;
    logic [DATA_W-1:0]        dout_data;
    logic                     pop;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output enable, din_dir, din_data, pop,
        input  fail, dout_dir, dout_data, count
    );

    modport slave (
        input  enable, din_dir, din_data, pop,
        output fail, dout_dir, dout_data, count
    );

endinterface

// File: rtl/recv_fifo.sv
// rtl/recv_fifo.sv - show-ahead FIFO storage with wrapping pointers and occupancy count
module recv_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W+1:0]       wr_pkt_i,
    output logic [DATA_W+1:0]       head_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W+1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Push and pop are pre-qualified by the caller; simultaneous ones keep count steady.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; an empty count masks stale data.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_pkt_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/port_recv_buffer.sv
// rtl/port_recv_buffer.sv - link receive buffer: accept logic, fail flag and masked head output
module port_recv_buffer
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    port_recv_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [1:0]        dir;
        logic [DATA_W-1:0] data;
    } pkt_w_t;

    logic          push_attempt;
    logic          pop_eff;
    logic          push_ok;
    logic          fail_q, fail_d;
    pkt_w_t        in_pkt;
    pkt_w_t        head_pkt;
    logic [CW-1:0] count;
    logic          empty;

    // A full FIFO still accepts when the head leaves on the same edge.
    always_comb begin
        push_attempt = dir_valid(bus.din_dir);
        pop_eff      = bus.pop & bus.enable & (count != '0);
        push_ok      = push_attempt & bus.enable & ((count < FULL_CNT) | pop_eff);
        fail_d       = push_attempt & ~push_ok;
        in_pkt.dir   = bus.din_dir;
        in_pkt.data  = bus.din_data;
    end

    recv_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push_ok),
        .pop_i    (pop_eff),
        .wr_pkt_i (in_pkt),
        .head_o   (head_pkt),
        .count_o  (count)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign empty         = (count == '0);
    assign bus.fail      = fail_q;
    assign bus.dout_dir  = empty ? DIR_NONE : head_pkt.dir;
    assign bus.dout_data = empty ? '0 : head_pkt.data;
    assign bus.count     = count;

endmodule

// File: tb/tb_port_recv_buffer.sv
// tb/tb_port_recv_buffer.sv - randomized and directed bench with queue reference model
module tb_port_recv_buffer;
    import router_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;

    port_recv_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    port_recv_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W+1:0] model_q [$];
    logic              exp_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0]        e_dir;
        logic [DATA_W-1:0] e_data;
        e_dir  = 2'b00;
        e_data = '0;
        if (model_q.size() > 0) begin
            e_dir  = model_q[0][DATA_W+1:DATA_W];
            e_data = model_q[0][DATA_W-1:0];
        end
        check({tag, ".fail"},  32'(bus.fail),      32'(exp_fail));
        check({tag, ".count"}, 32'(bus.count),     32'(model_q.size()));
        check({tag, ".dir"},   32'(bus.dout_dir),  32'(e_dir));
        check({tag, ".data"},  32'(bus.dout_data), 32'(e_data));
    endtask

    task automatic step(input logic en, input logic [1:0] dir, input logic [DATA_W-1:0] data,
                        input logic pop, input string tag);
        logic attempted, popped, stored;
        bus.enable   = en;
        bus.din_dir  = dir;
        bus.din_data = data;
        bus.pop      = pop;
        attempted = (dir != DIR_NONE);
        popped    = pop && en && (model_q.size() > 0);
        stored    = attempted && en && ((model_q.size() < DEPTH) || popped);
        exp_fail  = attempted && !stored;
        if (popped) void'(model_q.pop_front());
        if (stored) model_q.push_back({dir, data});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Called just after a clock edge: asserts reset between edges and checks the async clear.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b1;
        model_q.delete();
        exp_fail = 1'b0;
        #1;
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.enable   = 1'b1;
        bus.din_dir  = DIR_NONE;
        bus.din_data = '0;
        bus.pop      = 1'b0;
        exp_fail     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b0;

        step(1'b1, DIR_X, 8'hA5, 1'b0, "pre_rst_push");
        mid_reset("rst_mid");
        for (int i = 0; i < 5; i++) step(1'b1, DIR_NONE, 8'($urandom), 1'b0, "idle");

        step(1'b1, DIR_X,     8'h11, 1'b0, "fill0");
        step(1'b1, DIR_Y,     8'h22, 1'b0, "fill1");
        step(1'b1, DIR_LOCAL, 8'h33, 1'b0, "fill2");
        step(1'b1, DIR_X,     8'h44, 1'b0, "fill3");
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_head_dir", 32'(bus.dout_dir), 32'(DIR_X));
        check("fill_head_data", 32'(bus.dout_data), 32'h11);
        step(1'b1, DIR_Y, 8'h55, 1'b0, "overflow");
        check("overflow_fail", 32'(bus.fail), 32'd1);
        check("overflow_count", 32'(bus.count), 32'd4);

        step(1'b1, DIR_Y, 8'h55, 1'b1, "full_pushpop");
        check("full_pushpop_fail", 32'(bus.fail), 32'd0);
        check("full_pushpop_head", 32'({bus.dout_dir, bus.dout_data}), 32'({DIR_Y, 8'h22}));
        for (int i = 0; i < 4; i++) step(1'b1, DIR_NONE, 8'h00, 1'b1, "drain");
        check("drain_empty_dir", 32'(bus.dout_dir), 32'(DIR_NONE));

        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 2'($urandom_range(1, 3)), 8'(i), 1'b1, "wrap");
            check("wrap_count", 32'(bus.count), 32'd1);
        end

        step(1'b1, DIR_X, 8'h77, 1'b0, "en_prep");
        step(1'b0, DIR_LOCAL, 8'h66, 1'b1, "en_low");
        check("en_low_fail", 32'(bus.fail), 32'd1);
        check("en_low_count", 32'(bus.count), 32'd2);
        check("en_low_head", 32'(bus.dout_data), 32'h0A);
        step(1'b1, DIR_LOCAL, 8'h66, 1'b1, "en_resume");

        for (int i = 0; i < 8 && model_q.size() > 0; i++) step(1'b1, DIR_NONE, 8'h00, 1'b1, "drain2");
        step(1'b1, DIR_NONE, 8'h00, 1'b1, "pop_empty");
        check("pop_empty_count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 3; i++) step(1'b1, DIR_Y, 8'(8'hC0 + i), 1'b0, "refill");
        mid_reset("rst_fill");
        step(1'b1, DIR_NONE, 8'h00, 1'b0, "post_rst");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom), 8'($urandom),
                 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
